ccr_ctrl: RTL
=============

// Module: ccr_ctrl
// PURPOSE
//  Owns and sequences the 4-bit condition-code register (bit0 Z, bit1 N, bit2 C, bit3 V) for the core.
//  Arbitrates flag writes from the ALU, SETC/CLRC, interrupt entry (save and clear) and RTI (restore).
//  Keeps a shadow stack of saved CCR values for nested interrupts.
//  Resolves conditional branches against the up-to-date flags and stalls the pipe during save/restore.
// PARAMETERS
//  DEPTH  2  shadow-stack entries (max interrupt nesting); DEPTH >= 1
//  DW     2  depth-counter width; must hold the value DEPTH (clog2(DEPTH+1))
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous, active-low reset
//  alu_valid_i   in   1   ALU result completing this cycle
//  alu_flags_i   in   4   ALU flags {V,C,N,Z}
//  alu_mask_i    in   4   per-flag update enable for this instruction; 1 = write that bit
//  setc_i        in   1   SETC instruction: C <= 1
//  clrc_i        in   1   CLRC instruction: C <= 0
//  int_enter_i   in   1   interrupt accepted (1-cycle pulse)
//  rti_i         in   1   RTI executing (1-cycle pulse)
//  br_req_i      in   1   conditional branch needs resolution
//  br_cond_i     in   2   0 = JZ, 1 = JN, 2 = JC, 3 = JV
//  ccr_o         out  4   current CCR (registered)
//  br_valid_o    out  1   branch result valid (1-cycle pulse)
//  br_taken_o    out  1   branch taken, qualified by br_valid_o
//  stall_o       out  1   pipeline hold while in SAVE or RESTORE (combinational from state)
//  depth_o       out  DW  current shadow-stack occupancy
//  ovf_o         out  1   sticky: push attempted with stack full
//  unf_o         out  1   sticky: RTI attempted with stack empty
// BEHAVIOUR
//  Reset (rst = 0, async): ccr_o = 0, all stack entries = 0, depth_o = 0, ovf_o = 0, unf_o = 0;
//   br_valid_o = 0, br_taken_o = 0; state = RUN.
//  FSM states: RUN, SAVE, RESTORE.
//  RUN: form next_ccr in this order:
//   1. Start from ccr_o.
//   2. If alu_valid_i, bits with alu_mask_i = 1 take alu_flags_i.
//   3. Then clrc_i forces C = 0; else setc_i forces C = 1.
//   4. If clrc_i and setc_i are both high, clrc_i wins.
//   Priority: int_enter_i > rti_i > normal update.
//  RUN, int_enter_i = 1:
//   - Push next_ccr at the edge; depth + 1.
//   - ccr_o <= next_ccr at the same edge; state -> SAVE.
//   - Stack full (depth == DEPTH): push dropped, depth unchanged, ovf_o <= 1; still go to SAVE.
//   - rti_i in the same cycle is ignored.
//  SAVE (1 cycle): stall_o = 1; all write inputs ignored.
//   At exit edge: ccr_o <= 0; state -> RUN.
//  RUN, rti_i = 1 (int_enter_i = 0):
//   - ccr_o <= next_ccr; state -> RESTORE.
//  RESTORE (1 cycle): stall_o = 1; all write inputs ignored. At exit edge:
//   - depth > 0: ccr_o <= top entry; depth - 1.
//   - depth == 0: ccr_o unchanged; unf_o <= 1.
//   - state -> RUN.
//  RUN, neither int_enter_i nor rti_i: ccr_o <= next_ccr every cycle (a hold when no writes).
//  Branch resolution (RUN only):
//   - br_req_i = 1 -> next cycle br_valid_o = 1 and br_taken_o = next_ccr[br_cond_i].
//   - So a same-cycle ALU/SETC/CLRC update is forwarded (1-cycle latency).
//   - br_req_i in SAVE/RESTORE is ignored (br_valid_o = 0); the requester holds the request while stall_o = 1.
//   - br_req_i with int_enter_i or rti_i in RUN is still resolved, using next_ccr.
//   - br_taken_o = 0 whenever br_valid_o = 0.
//  Stack: LIFO; entries [0..DEPTH-1]; top = entry[depth-1].
//   Restored entries are not cleared. ovf_o/unf_o clear only on reset.
//  Reset mid-SAVE/RESTORE: everything returns to reset values immediately; no partial push/pop survives.
// TESTING
//  1. alu_valid = 1, flags = 4'b1111, mask = 4'b0101 from reset -> ccr_o = 4'b0101 next cycle.
//     Then setc = 1 and clrc = 1 together -> C = 0, ccr_o = 4'b0001.
//  2. ccr = 4'b0110; int_enter with alu flags = 4'b0001, mask = 4'hF -> depth = 1, stall_o high 1 cycle,
//     ccr_o = 4'b0001, then 0. Then rti -> stall 1 cycle, ccr_o = 4'b0001, depth = 0.
//  3. Nested: DEPTH = 2, three int_enter pulses (spaced) -> depth = 2, ovf_o = 1.
//     Three rti -> values popped in LIFO order, depth = 0, third rti sets unf_o = 1 with ccr_o unchanged.
//  4. br_req, cond = JC, same cycle alu sets C = 1 (mask = 4'b0100) -> br_valid = 1, br_taken = 1 next cycle.
//     br_req during SAVE -> no br_valid.
//  5. Assert rst low during RESTORE with depth = 1 -> ccr_o = 0, depth_o = 0, stall_o = 0 immediately (async).
//  6. int_enter and rti in the same cycle -> push occurs, rti ignored, depth + 1, no unf_o.

Source files
------------

// File: rtl/ccr_ctrl.sv
// ccr_ctrl: owner of the 4-bit condition-code register {V,C,N,Z}.
// Merges ALU / SETC / CLRC flag writes and saves the CCR on interrupt entry.
// The CCR is cleared after a save and restored on RTI from a shadow LIFO.
// Conditional branches are resolved against the forwarded flags.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   alu_valid_i/flags/mask   ALU flag write with per-bit enable
//   setc_i, clrc_i           force C high / low (clrc wins)
//   int_enter_i, rti_i       interrupt entry (save) and return (restore) pulses
//   br_req_i, br_cond_i      branch resolution request, 0=Z 1=N 2=C 3=V
//   ccr_o                    registered CCR
//   br_valid_o, br_taken_o   branch result, one cycle after the request
//   stall_o                  pipeline hold during SAVE / RESTORE
//   depth_o, ovf_o, unf_o    shadow-stack occupancy and sticky error flags
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | normal flag updates and branch resolution
// SAVE    | one-cycle hold after the push; CCR cleared on exit
// RESTORE | one-cycle hold; top entry popped into the CCR on exit

module ccr_ctrl #(
    parameter int DEPTH = 2,
    parameter int DW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid_i,
    input  logic [3:0]    alu_flags_i,
    input  logic [3:0]    alu_mask_i,
    input  logic          setc_i,
    input  logic          clrc_i,
    input  logic          int_enter_i,
    input  logic          rti_i,
    input  logic          br_req_i,
    input  logic [1:0]    br_cond_i,
    output logic [3:0]    ccr_o,
    output logic          br_valid_o,
    output logic          br_taken_o,
    output logic          stall_o,
    output logic [DW-1:0] depth_o,
    output logic          ovf_o,
    output logic          unf_o
);

    typedef enum logic [1:0] {RUN, SAVE, RESTORE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    ccr_q;
    logic [3:0]    next_ccr;
    logic [3:0]    top_entry;
    logic [3:0]    stack_q [DEPTH];
    logic [DW-1:0] depth_q;
    logic          ovf_q, unf_q;
    logic          br_valid_q, br_taken_q;
    logic          stack_full, stack_empty;
    logic          br_fire;

    assign stack_full  = (depth_q == DW'(DEPTH));
    assign stack_empty = (depth_q == '0);
    assign br_fire     = (state_q == RUN) && br_req_i;

    // ALU mask merge first, then the C override; clrc beats setc.
    always_comb begin
        next_ccr = ccr_q;
        if (alu_valid_i) begin
            next_ccr = (ccr_q & ~alu_mask_i) | (alu_flags_i & alu_mask_i);
        end
        if (clrc_i) begin
            next_ccr[2] = 1'b0;
        end else if (setc_i) begin
            next_ccr[2] = 1'b1;
        end
    end

    // Explicit compare against each index keeps the select in range for any DEPTH.
    always_comb begin
        top_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (DW'(i) == depth_q - DW'(1)) begin
                top_entry = stack_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        case (state_q)
            RUN: begin
                if (int_enter_i) begin
                    state_d = SAVE;
                end else if (rti_i) begin
                    state_d = RESTORE;
                end
            end
            SAVE: begin
                stall_o = 1'b1;
                state_d = RUN;
            end
            RESTORE: begin
                stall_o = 1'b1;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ccr_q      <= '0;
            depth_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            br_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            br_valid_q <= br_fire;
            br_taken_q <= br_fire && next_ccr[br_cond_i];
            case (state_q)
                RUN: begin
                    ccr_q <= next_ccr;
                    if (int_enter_i) begin
                        if (!stack_full) begin
                            for (int i = 0; i < DEPTH; i++) begin
                                if (DW'(i) == depth_q) begin
                                    stack_q[i] <= next_ccr;
                                end
                            end
                            depth_q <= depth_q + DW'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                SAVE: begin
                    ccr_q <= '0;
                end
                RESTORE: begin
                    if (!stack_empty) begin
                        ccr_q   <= top_entry;
                        depth_q <= depth_q - DW'(1);
                    end else begin
                        unf_q <= 1'b1;
                    end
                end
                default: begin
                    ccr_q <= ccr_q;
                end
            endcase
        end
    end

    assign ccr_o      = ccr_q;
    assign depth_o    = depth_q;
    assign ovf_o      = ovf_q;
    assign unf_o      = unf_q;
    assign br_valid_o = br_valid_q;
    assign br_taken_o = br_taken_q;

endmodule
